// File: rtl/gb80_pkg.sv
// gb80_pkg: shared region/state enums, address map constants and decode helper for the gb80 memory controller
package gb80_pkg;
  typedef enum logic [2:0] {REG_WRAM, REG_HRAM, REG_ECHO, REG_NULL, REG_EXT} region_t;
  typedef enum logic [1:0] {ST_IDLE, ST_INT, ST_EXT, ST_RESP} state_t;
  localparam logic [15:0] WRAM_BASE  = 16'hC000;
  localparam logic [15:0] WRAM_LIMIT = 16'hDFFF;
  localparam logic [15:0] ECHO_BASE  = 16'hE000;
  localparam logic [15:0] ECHO_LIMIT = 16'hFDFF;
  localparam logic [15:0] NULL_BASE  = 16'hFEA0;
  localparam logic [15:0] NULL_LIMIT = 16'hFEFF;
  localparam logic [15:0] HRAM_BASE  = 16'hFF80;
  localparam logic [15:0] HRAM_LIMIT = 16'hFFFE;
  localparam logic [7:0]  OPEN_BUS_DATA = 8'hFF;
  function automatic region_t region_of(input logic [15:0] a);
    return (a >= WRAM_BASE && a <= WRAM_LIMIT) ? REG_WRAM :
           (a >= ECHO_BASE && a <= ECHO_LIMIT) ? REG_ECHO :
           (a >= NULL_BASE && a <= NULL_LIMIT) ? REG_NULL :
           (a >= HRAM_BASE && a <= HRAM_LIMIT) ? REG_HRAM : REG_EXT;
  endfunction
endpackage

// File: rtl/gb80_sync_ram.sv
// gb80_sync_ram: single-port synchronous RAM, 1-cycle read, no array reset
//   clk; en enables the access; we writes wdata at addr; rdata holds the last read word
module gb80_sync_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**AW];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
endmodule

// File: rtl/gb80_memory_controller.sv
// gb80_memory_controller: CPU bus responder routing to WRAM, HRAM, unusable space or an external req/ack port
//   CPU side: i_req/i_we/i_addr/i_wdata in, o_ready/o_rvalid/o_rdata/o_err out
//   external side: o_ext_req/o_ext_we/o_ext_addr/o_ext_wdata out, i_ext_ack/i_ext_rdata in
//   GB80_ECHO_RAM_EN: when defined E000-FDFF aliases WRAM, otherwise it reads FF and drops writes
module gb80_memory_controller
  import gb80_pkg::*;
#(
  parameter int WRAM_AW     = 13,
  parameter int HRAM_AW     = 7,
  parameter int EXT_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  output logic        o_ready,
  output logic        o_rvalid,
  output logic [7:0]  o_rdata,
  output logic        o_err,
  output logic        o_ext_req,
  output logic        o_ext_we,
  output logic [15:0] o_ext_addr,
  output logic [7:0]  o_ext_wdata,
  input  logic        i_ext_ack,
  input  logic [7:0]  i_ext_rdata
);
  localparam int CW = $clog2(EXT_TIMEOUT + 1);
  state_t state;
  region_t region;
  logic we_q, ram_rd, wram_hit, hram_hit;
  logic [WRAM_AW-1:0] ram_idx;
  logic [7:0] wdata_q, rdata_q, wram_q, hram_q, ram_data;
  logic [CW-1:0] cnt;
`ifdef GB80_ECHO_RAM_EN
  assign wram_hit = region == REG_WRAM || region == REG_ECHO;
`else
  assign wram_hit = region == REG_WRAM;
`endif
  assign hram_hit = region == REG_HRAM;
  assign ram_data = hram_hit ? hram_q : wram_q;
  // RAM read data only arrives during RESP, so it bypasses the hold register for that cycle
  assign o_rdata = ram_rd ? ram_data : rdata_q;
  gb80_sync_ram #(.AW(WRAM_AW)) u_wram (
    .clk(i_clk), .en(state == ST_INT && wram_hit), .we(we_q),
    .addr(ram_idx), .wdata(wdata_q), .rdata(wram_q)
  );
  gb80_sync_ram #(.AW(HRAM_AW)) u_hram (
    .clk(i_clk), .en(state == ST_INT && hram_hit), .we(we_q),
    .addr(ram_idx[HRAM_AW-1:0]), .wdata(wdata_q), .rdata(hram_q)
  );
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      state       <= ST_IDLE;
      region      <= REG_NULL;
      we_q        <= 1'b0;
      ram_idx     <= '0;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      ram_rd      <= 1'b0;
      cnt         <= '0;
      o_ready     <= 1'b1;
      o_rvalid    <= 1'b0;
      o_err       <= 1'b0;
      o_ext_req   <= 1'b0;
      o_ext_we    <= 1'b0;
      o_ext_addr  <= 16'h0000;
      o_ext_wdata <= 8'h00;
    end else begin
      o_rvalid <= 1'b0;
      o_err    <= 1'b0;
      case (state)
        ST_IDLE:
          if (i_req) begin
            we_q    <= i_we;
            ram_idx <= i_addr[WRAM_AW-1:0];
            wdata_q <= i_wdata;
            region  <= region_of(i_addr);
            o_ready <= 1'b0;
            if (region_of(i_addr) == REG_EXT) begin
              state       <= ST_EXT;
              cnt         <= '0;
              o_ext_req   <= 1'b1;
              o_ext_we    <= i_we;
              o_ext_addr  <= i_addr;
              o_ext_wdata <= i_wdata;
            end else
              state <= ST_INT;
          end
        ST_INT: begin
          state    <= ST_RESP;
          o_rvalid <= 1'b1;
          ram_rd   <= !we_q && (wram_hit || hram_hit);
          if (!we_q && !(wram_hit || hram_hit)) rdata_q <= OPEN_BUS_DATA;
        end
        ST_EXT:
          // ack is tested first so an ack on the final cycle beats the timeout
          if (i_ext_ack) begin
            state     <= ST_RESP;
            o_rvalid  <= 1'b1;
            o_ext_req <= 1'b0;
            if (!we_q) rdata_q <= i_ext_rdata;
          end else if (cnt == CW'(EXT_TIMEOUT - 1)) begin
            state     <= ST_RESP;
            o_rvalid  <= 1'b1;
            o_err     <= 1'b1;
            o_ext_req <= 1'b0;
            if (!we_q) rdata_q <= OPEN_BUS_DATA;
          end else if (cnt != '1)
            cnt <= cnt + 1'b1;
        ST_RESP: begin
          state   <= ST_IDLE;
          o_ready <= 1'b1;
          ram_rd  <= 1'b0;
          if (ram_rd) rdata_q <= ram_data;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_gb80_memory_controller.sv
// tb_gb80_memory_controller: directed plus randomized checks of the gb80 memory controller against an address-map model
module tb_gb80_memory_controller;
  localparam int TO = 8;
`ifdef GB80_ECHO_RAM_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif
  logic i_clk = 1'b0, i_reset = 1'b0, i_req = 1'b0, i_we = 1'b0, i_ext_ack = 1'b0;
  logic [15:0] i_addr = 16'h0000;
  logic [7:0] i_wdata = 8'h00, i_ext_rdata = 8'h00;
  logic o_ready, o_rvalid, o_err, o_ext_req, o_ext_we;
  logic [7:0] o_rdata, o_ext_wdata;
  logic [15:0] o_ext_addr;
  int checks = 0, failures = 0;
  logic [7:0] mem_m [int];
  logic [7:0] last_rd = 8'h00;

  gb80_memory_controller #(.WRAM_AW(13), .HRAM_AW(7), .EXT_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_ready(o_ready), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
    .o_err(o_err), .o_ext_req(o_ext_req), .o_ext_we(o_ext_we), .o_ext_addr(o_ext_addr),
    .o_ext_wdata(o_ext_wdata), .i_ext_ack(i_ext_ack), .i_ext_rdata(i_ext_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 = WRAM, 1 = HRAM, 2 = unusable, 3 = external
  function automatic int kind(input int a);
    if (a >= 'hC000 && a <= 'hDFFF) return 0;
    if (a >= 'hE000 && a <= 'hFDFF) return ECHO ? 0 : 2;
    if (a >= 'hFE00 && a <= 'hFE9F) return 3;
    if (a >= 'hFEA0 && a <= 'hFEFF) return 2;
    if (a >= 'hFF80 && a <= 'hFFFE) return 1;
    return 3;
  endfunction

  function automatic int key(input int a);
    return kind(a) == 0 ? ('hC000 + (a % 'h2000)) : a;
  endfunction

  // ack_at: req cycle (1-based) on which ack is driven; anything above TO means never
  task automatic txn(input bit we, input logic [15:0] a, input logic [7:0] wd,
                     input int ack_at, input logic [7:0] xd, input string tag);
    int k, cyc, reqc, exp_lat, exp_reqc;
    bit done, exp_err;
    logic [7:0] exp_d;
    k = kind(int'(a));
    exp_err = (k == 3) && (ack_at > TO);
    exp_lat = (k != 3) ? 2 : (exp_err ? TO + 1 : ack_at + 1);
    exp_reqc = (k != 3) ? 0 : (exp_err ? TO : ack_at);
    if (we) begin
      exp_d = last_rd;
      if (k <= 1) mem_m[key(int'(a))] = wd;
    end else if (k == 2) exp_d = 8'hFF;
    else if (k == 3) exp_d = exp_err ? 8'hFF : xd;
    else exp_d = mem_m.exists(key(int'(a))) ? mem_m[key(int'(a))] : 8'hxx;
    last_rd = exp_d;
    chk({tag, "_ready"}, o_ready, 1);
    i_req = 1'b1; i_we = we; i_addr = a; i_wdata = wd;
    @(negedge i_clk);
    i_req = 1'b0; i_we = $urandom_range(0, 1); i_addr = 16'($urandom); i_wdata = 8'($urandom);
    cyc = 1; reqc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      if (o_rvalid) done = 1'b1;
      else begin
        if (o_ext_req) begin
          reqc++;
          chk({tag, "_ext_addr"}, o_ext_addr, a);
          chk({tag, "_ext_we"}, o_ext_we, we);
          if (we) chk({tag, "_ext_wdata"}, o_ext_wdata, wd);
          if (reqc == ack_at) begin i_ext_ack = 1'b1; i_ext_rdata = xd; end
        end
        @(negedge i_clk);
        i_ext_ack = 1'b0;
        i_ext_rdata = 8'($urandom);
        cyc++;
      end
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat"}, cyc, exp_lat);
    chk({tag, "_reqc"}, reqc, exp_reqc);
    chk({tag, "_rdata"}, o_rdata, exp_d);
    chk({tag, "_err"}, o_err, exp_err);
    @(negedge i_clk);
    chk({tag, "_rvalid_pulse"}, o_rvalid, 0);
    chk({tag, "_err_pulse"}, o_err, 0);
    chk({tag, "_rdata_hold"}, o_rdata, exp_d);
  endtask

  initial begin
    logic [15:0] a;
    repeat (3) @(negedge i_clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_rvalid", o_rvalid, 0);
    chk("rst_rdata", o_rdata, 8'h00);
    chk("rst_err", o_err, 0);
    chk("rst_ext_req", o_ext_req, 0);
    chk("rst_ext_we", o_ext_we, 0);
    chk("rst_ext_addr", o_ext_addr, 16'h0000);
    chk("rst_ext_wdata", o_ext_wdata, 8'h00);
    i_reset = 1'b1;
    txn(1'b1, 16'hC123, 8'h5A, 99, 8'h00, "wr_c123");
    txn(1'b0, 16'hC123, 8'h00, 99, 8'h00, "rd_c123");
    txn(1'b1, 16'hC010, 8'hA5, 99, 8'h00, "wr_c010");
    txn(1'b0, 16'hE010, 8'h00, 99, 8'h00, "rd_e010");
    txn(1'b1, 16'hFFFE, 8'h3C, 99, 8'h00, "wr_fffe");
    txn(1'b0, 16'hFFFE, 8'h00, 99, 8'h00, "rd_fffe");
    txn(1'b0, 16'h0150, 8'h00, 3, 8'h3C, "rd_0150");
    txn(1'b0, 16'hFFFF, 8'h00, 3, 8'h81, "rd_ffff");
    txn(1'b1, 16'hFE10, 8'h66, 2, 8'h00, "wr_oam");
    txn(1'b0, 16'h4000, 8'h00, 99, 8'h12, "rd_timeout");
    txn(1'b1, 16'h9000, 8'h44, 99, 8'h00, "wr_timeout");
    txn(1'b0, 16'h8000, 8'h00, TO, 8'h42, "rd_ack_last");
    txn(1'b1, 16'hFEA0, 8'h77, 99, 8'h00, "wr_fea0");
    txn(1'b0, 16'hFEA0, 8'h00, 99, 8'h00, "rd_fea0");
    for (int i = 0; i < 16; i++) begin
      txn(1'b1, 16'(16'hC000 + i), 8'($urandom), 99, 8'h00, "fill_wram");
      txn(1'b1, 16'(16'hFF80 + i), 8'($urandom), 99, 8'h00, "fill_hram");
    end
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: a = 16'(16'hC000 + $urandom_range(0, 15));
        1: a = 16'(16'hE000 + $urandom_range(0, 15));
        2: a = 16'(16'hFF80 + $urandom_range(0, 15));
        3: a = 16'(16'hFEA0 + $urandom_range(0, 95));
        default: a = ($urandom_range(0, 3) == 0) ? 16'hFFFF :
                     ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 'hBFFF)) :
                     16'(16'hFE00 + $urandom_range(0, 159));
      endcase
      txn(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(1, TO + 2), 8'($urandom), "rand");
    end
    i_req = 1'b1; i_we = 1'b0; i_addr = 16'h2000;
    @(negedge i_clk);
    i_req = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("mid_ext_req_before", o_ext_req, 1);
    #2 i_reset = 1'b0;
    #1;
    chk("mid_ext_req_drop", o_ext_req, 0);
    chk("mid_ready", o_ready, 1);
    chk("mid_rvalid", o_rvalid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("mid_no_rvalid", o_rvalid, 0);
    end
    i_reset = 1'b1;
    last_rd = 8'h00;
    txn(1'b0, 16'hFFFE, 8'h00, 99, 8'h00, "post_rst_fffe");
    txn(1'b0, 16'hC123, 8'h00, 99, 8'h00, "post_rst_c123");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
